// File: rtl/xor_engine_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xor_engine_arbiter
//  Summary  : Round-robin arbiter/sequencer sharing one xorEncr engine among
//             NUM_REQ requesters, with a watchdog that resets a hung engine.
//  Revision : 1.0
// ============================================================================
module xor_engine_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_rw,
    output logic [NUM_REQ-1:0] req_done,
    output logic [NUM_REQ-1:0] req_err,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               eng_start,
    output logic               eng_rw_flag,
    output logic               eng_rst,
    input  logic               eng_done,
    output logic [7:0]         err_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = PTR_W + 1;
    localparam logic                 c_WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] c_WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0]     c_PTR_LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_ABORT     = 3'd3,
        S_ACK       = 3'd4
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_sel;
    logic [CNT_WIDTH-1:0] r_wdog;
    logic [7:0]           r_err_count;
    logic [NUM_REQ-1:0]   r_req_done;
    logic [NUM_REQ-1:0]   r_req_err;
    logic                 r_rw_flag;

    logic                 w_found;
    logic [PTR_W-1:0]     w_sel;
    logic [IDX_W-1:0]     w_idx;
    logic [PTR_W-1:0]     w_next_ptr;

    // Search starts at rr_ptr and wraps, so the last owner is served last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + IDX_W'(i);
            if (w_idx >= IDX_W'(NUM_REQ)) begin
                w_idx = w_idx - IDX_W'(NUM_REQ);
            end
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_next_ptr = (r_sel == c_PTR_LAST) ? '0 : r_sel + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_sel       <= '0;
            r_wdog      <= '0;
            r_err_count <= '0;
            r_req_done  <= '0;
            r_req_err   <= '0;
            r_rw_flag   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel     <= w_sel;
                        r_grant   <= NUM_REQ'(1) << w_sel;
                        r_rw_flag <= req_rw[w_sel];
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A done arriving on the timeout cycle still completes cleanly.
                    if (eng_done) begin
                        r_req_done <= r_grant;
                        r_req_err  <= '0;
                        r_state    <= S_ACK;
                    end else if (c_WDOG_EN && (r_wdog == c_WDOG_LAST)) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_wdog <= r_wdog + CNT_WIDTH'(1);
                    end
                end
                S_ABORT: begin
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    r_req_done <= r_grant;
                    r_req_err  <= r_grant;
                    r_state    <= S_ACK;
                end
                S_ACK: begin
                    r_grant    <= '0;
                    r_rr_ptr   <= w_next_ptr;
                    r_req_done <= '0;
                    r_req_err  <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign req_done    = r_req_done;
    assign req_err     = r_req_err;
    assign err_count   = r_err_count;
    assign eng_rw_flag = r_rw_flag;
    assign eng_start   = (r_state == S_ISSUE);
    assign eng_rst     = (r_state == S_ABORT);
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
